// File: rtl/notch_sweep_ctrl_if.sv
// Host/front-end signal bundle for notch_sweep_ctrl: sweep control, configuration,
// NCO frequency word, measurement handshake and notch results.
interface notch_sweep_ctrl_if #(
    parameter int FW_W     = 24,
    parameter int MAG_W    = 16,
    parameter int NPTS_W   = 8,
    parameter int SETTLE_W = 16
) ();
    logic                start;
    logic                abort;
    logic [FW_W-1:0]     cfg_f_start;
    logic [FW_W-1:0]     cfg_f_step;
    logic [NPTS_W-1:0]   cfg_npts;
    logic [SETTLE_W-1:0] cfg_settle;
    logic [FW_W-1:0]     freq_word;
    logic                freq_valid;
    logic                meas_req;
    logic                meas_ack;
    logic [MAG_W-1:0]    meas_mag;
    logic                busy;
    logic                done;
    logic [NPTS_W-1:0]   notch_idx;
    logic [FW_W-1:0]     notch_fw;
    logic [MAG_W-1:0]    notch_mag;

    modport master (
        output start, abort, cfg_f_start, cfg_f_step, cfg_npts, cfg_settle,
        output meas_ack, meas_mag,
        input  freq_word, freq_valid, meas_req, busy, done,
        input  notch_idx, notch_fw, notch_mag
    );

    modport slave (
        input  start, abort, cfg_f_start, cfg_f_step, cfg_npts, cfg_settle,
        input  meas_ack, meas_mag,
        output freq_word, freq_valid, meas_req, busy, done,
        output notch_idx, notch_fw, notch_mag
    );
endinterface

// File: rtl/notch_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO word, settles, measures gain and tracks the minimum.
// Define NOTCH_SWEEP_AVG2_EN to average two measurements per point.
module notch_sweep_ctrl #(
    parameter int FW_W     = 24,
    parameter int MAG_W    = 16,
    parameter int NPTS_W   = 8,
    parameter int SETTLE_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    notch_sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_GAP, S_MEAS2, S_UPDATE, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [FW_W-1:0]     step_q, step_d;
    logic [NPTS_W-1:0]   npts_q, npts_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [FW_W-1:0]     fw_q, fw_d;
    logic [NPTS_W-1:0]   idx_q, idx_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic [MAG_W-1:0]    m1_q, m1_d;
    logic [MAG_W-1:0]    min_mag_q, min_mag_d;
    logic [NPTS_W-1:0]   min_idx_q, min_idx_d;
    logic [FW_W-1:0]     min_fw_q, min_fw_d;

    logic [FW_W-1:0]     freq_word_q;
    logic                freq_valid_q;
    logic                meas_req_q;
    logic                busy_q;
    logic                done_q;
    logic [NPTS_W-1:0]   notch_idx_q;
    logic [FW_W-1:0]     notch_fw_q;
    logic [MAG_W-1:0]    notch_mag_q;

    // Mean of two samples through a one-bit-wider sum, truncated.
    function automatic logic [MAG_W-1:0] avg2(input logic [MAG_W-1:0] a, input logic [MAG_W-1:0] b);
        logic [MAG_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[MAG_W:1];
    endfunction

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        npts_d    = npts_q;
        settle_d  = settle_q;
        fw_d      = fw_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        m1_d      = m1_q;
        min_mag_d = min_mag_q;
        min_idx_d = min_idx_q;
        min_fw_d  = min_fw_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    step_d    = bus.cfg_f_step;
                    npts_d    = bus.cfg_npts;
                    settle_d  = bus.cfg_settle;
                    fw_d      = bus.cfg_f_start;
                    idx_d     = '0;
                    min_mag_d = '1;
                    min_idx_d = '0;
                    min_fw_d  = bus.cfg_f_start;
                    state_d   = (bus.cfg_npts == '0) ? S_DONE : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = settle_q;
                state_d = (settle_q == '0) ? S_MEAS : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = S_MEAS;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            S_MEAS: begin
                if (bus.meas_ack) begin
`ifdef NOTCH_SWEEP_AVG2_EN
                    m1_d    = bus.meas_mag;
                    state_d = S_GAP;
`else
                    mag_d   = bus.meas_mag;
                    state_d = S_UPDATE;
`endif
                end else begin
                    state_d = S_MEAS;
                end
            end
            // One idle cycle between the paired requests; unreachable in the single-sample build.
            S_GAP: begin
`ifdef NOTCH_SWEEP_AVG2_EN
                state_d = S_MEAS2;
`else
                state_d = S_IDLE;
`endif
            end
            S_MEAS2: begin
                if (bus.meas_ack) begin
                    mag_d   = avg2(m1_q, bus.meas_mag);
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_MEAS2;
                end
            end
            S_UPDATE: begin
                if (mag_q < min_mag_q) begin
                    min_mag_d = mag_q;
                    min_idx_d = idx_q;
                    min_fw_d  = fw_q;
                end else begin
                    min_mag_d = min_mag_q;
                end
                fw_d    = fw_q + step_q;
                idx_d   = idx_q + NPTS_W'(1);
                state_d = (idx_q == npts_q - NPTS_W'(1)) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state, shadow configuration and minimum tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            npts_q    <= '0;
            settle_q  <= '0;
            fw_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            mag_q     <= '0;
            m1_q      <= '0;
            min_mag_q <= '1;
            min_idx_q <= '0;
            min_fw_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            npts_q    <= npts_d;
            settle_q  <= settle_d;
            fw_q      <= fw_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            m1_q      <= m1_d;
            min_mag_q <= min_mag_d;
            min_idx_q <= min_idx_d;
            min_fw_q  <= min_fw_d;
        end
    end

    // Outputs are decoded from the next state so each one is aligned with the state it reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_word_q  <= '0;
            freq_valid_q <= 1'b0;
            meas_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            notch_idx_q  <= '0;
            notch_fw_q   <= '0;
            notch_mag_q  <= '1;
        end else begin
            freq_valid_q <= (state_d == S_LOAD);
            meas_req_q   <= (state_d == S_MEAS) || (state_d == S_MEAS2);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            if (state_d == S_LOAD) begin
                freq_word_q <= fw_d;
            end
            // Empty sweeps reach DONE straight from IDLE and leave the previous result intact.
            if ((state_q == S_UPDATE) && (state_d == S_DONE)) begin
                notch_idx_q <= min_idx_d;
                notch_fw_q  <= min_fw_d;
                notch_mag_q <= min_mag_d;
            end
        end
    end

    assign bus.freq_word  = freq_word_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.meas_req   = meas_req_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.notch_idx  = notch_idx_q;
    assign bus.notch_fw   = notch_fw_q;
    assign bus.notch_mag  = notch_mag_q;

endmodule

// File: tb/tb_notch_sweep_ctrl.sv
// Scoreboard bench for notch_sweep_ctrl: the driver queues expected words/results,
// a monitor pops and compares them whenever freq_valid or done is presented.
module tb_notch_sweep_ctrl;
    localparam int FW_W = 24, MAG_W = 16, NPTS_W = 8, SETTLE_W = 16;

    typedef struct packed {
        logic [7:0]  idx;
        logic [23:0] fw;
        logic [15:0] mag;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    notch_sweep_ctrl_if #(.FW_W(FW_W), .MAG_W(MAG_W), .NPTS_W(NPTS_W), .SETTLE_W(SETTLE_W)) bus ();
    notch_sweep_ctrl #(.FW_W(FW_W), .MAG_W(MAG_W), .NPTS_W(NPTS_W), .SETTLE_W(SETTLE_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [23:0] fwq[$];
    res_t        doneq[$];
    logic [15:0] magq[$];
    int          total = 0;
    int          bad = 0;
    int          ack_delay = 0;
    logic [15:0] cur_settle = 16'd0;
    int          req_rises = 0;
    int          fv_cnt = 0;
    res_t        last_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_done(input logic [7:0] i, input logic [23:0] f, input logic [15:0] m);
        res_t r;
        r.idx = i; r.fw = f; r.mag = m;
        doneq.push_back(r);
        last_res = r;
    endfunction

    function automatic void push_mag(input logic [15:0] m);
        magq.push_back(m);
`ifdef NOTCH_SWEEP_AVG2_EN
        magq.push_back(m);
`endif
    endfunction

    function automatic int sweep_cycles(input int np, input int se, input int dly);
        int pp;
        pp = 1 + se + (dly + 1) + 1;
`ifdef NOTCH_SWEEP_AVG2_EN
        pp = pp + (dly + 1) + 1;
`endif
        return 2 + np * pp;
    endfunction

    task automatic check_reset_values();
        check("rst_freq_word", bus.freq_word, 0);
        check("rst_freq_valid", bus.freq_valid, 0);
        check("rst_meas_req", bus.meas_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_notch_idx", bus.notch_idx, 0);
        check("rst_notch_fw", bus.notch_fw, 0);
        check("rst_notch_mag", bus.notch_mag, 32'hFFFF);
    endtask

    // Measurement front end: ack after ack_delay cycles of meas_req, with the next queued magnitude.
    initial begin : responder
        int cnt;
        cnt = 0;
        bus.meas_ack = 1'b0;
        bus.meas_mag = 16'h0;
        forever begin
            @(posedge clk); #1;
            bus.meas_ack = 1'b0;
            if (bus.meas_req) begin
                if (cnt >= ack_delay) begin
                    check("mag_available", magq.size() != 0, 1);
                    bus.meas_mag = (magq.size() != 0) ? magq.pop_front() : 16'h0;
                    bus.meas_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares every presented frequency word and every done result against the queues.
    initial begin : monitor
        bit   prev_fv;
        bit   prev_req;
        res_t r;
        prev_fv = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fv = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (prev_fv) check("req_after_load", bus.meas_req, cur_settle == 16'd0);
                if (bus.freq_valid) begin
                    fv_cnt++;
                    check("fv_expected", fwq.size() != 0, 1);
                    if (fwq.size() != 0) check("freq_word", bus.freq_word, fwq.pop_front());
                end
                if (bus.meas_req && !prev_req) req_rises++;
                if (bus.done) begin
                    check("done_expected", doneq.size() != 0, 1);
                    if (doneq.size() != 0) begin
                        r = doneq.pop_front();
                        check("notch_idx", bus.notch_idx, r.idx);
                        check("notch_fw", bus.notch_fw, r.fw);
                        check("notch_mag", bus.notch_mag, r.mag);
                    end
                end
                prev_fv = bus.freq_valid;
                prev_req = bus.meas_req;
            end
        end
    end

    task automatic sweep(input logic [23:0] fs, input logic [23:0] st, input logic [7:0] np,
                         input logic [15:0] se, input int dly, input bit mid);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.cfg_f_start = fs;
        bus.cfg_f_step = st;
        bus.cfg_npts = np;
        bus.cfg_settle = se;
        ack_delay = dly;
        cur_settle = se;
        bus.start = 1'b1;
        while (!seen && n < 2000) begin
            @(posedge clk); n++; #1;
            bus.start = 1'b0;
            if (n == 1) check("busy_after_start", bus.busy, 1);
            if (mid && n == 5) begin
                bus.start = 1'b1;
                bus.cfg_f_start = 24'hABCDEF;
                bus.cfg_f_step = 24'h000001;
                bus.cfg_npts = 8'd9;
                bus.cfg_settle = 16'd0;
            end
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("sweep_cycles", n + 1, sweep_cycles(int'(np), int'(se), dly));
        @(posedge clk); #1;
        check("idle_after_done", bus.busy, 0);
        check("words_consumed", fwq.size(), 0);
        check("results_consumed", doneq.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int  n;
        int  base;
        int  r0;
        bit  hit;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_f_start = 24'h0;
        bus.cfg_f_step = 24'h0;
        bus.cfg_npts = 8'd0;
        bus.cfg_settle = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sweep
        fwq.push_back(24'h000100); fwq.push_back(24'h000110);
        fwq.push_back(24'h000120); fwq.push_back(24'h000130);
        push_mag(16'd500); push_mag(16'd200); push_mag(16'd300); push_mag(16'd400);
        expect_done(8'd1, 24'h000110, 16'd200);
        sweep(24'h000100, 24'h000010, 8'd4, 16'd3, 2, 1'b0);

        // Ties keep the earliest index; settle=0
        fwq.push_back(24'h000200); fwq.push_back(24'h000208);
        fwq.push_back(24'h000210); fwq.push_back(24'h000218);
        push_mag(16'd100); push_mag(16'd100); push_mag(16'd50); push_mag(16'd50);
        expect_done(8'd2, 24'h000210, 16'd50);
        sweep(24'h000200, 24'h000008, 8'd4, 16'd0, 0, 1'b0);

        // Frequency word wrap
        fwq.push_back(24'hFFFFF0); fwq.push_back(24'h000000); fwq.push_back(24'h000010);
        push_mag(16'd7); push_mag(16'd9); push_mag(16'd8);
        expect_done(8'd0, 24'hFFFFF0, 16'd7);
        sweep(24'hFFFFF0, 24'h000010, 8'd3, 16'd1, 1, 1'b0);

        // Empty sweep keeps the previous result
        expect_done(8'd0, 24'hFFFFF0, 16'd7);
        sweep(24'h123456, 24'h000001, 8'd0, 16'd4, 0, 1'b0);

        // Start and config changes mid-sweep are ignored
        fwq.push_back(24'h000040); fwq.push_back(24'h000044);
        push_mag(16'd60); push_mag(16'd30);
        expect_done(8'd1, 24'h000044, 16'd30);
        sweep(24'h000040, 24'h000004, 8'd2, 16'd2, 1, 1'b1);

`ifdef NOTCH_SWEEP_AVG2_EN
        r0 = req_rises;
        fwq.push_back(24'h000500); fwq.push_back(24'h000520);
        magq.push_back(16'd301); magq.push_back(16'd300);
        magq.push_back(16'd101); magq.push_back(16'd100);
        expect_done(8'd1, 24'h000520, 16'd100);
        sweep(24'h000500, 24'h000020, 8'd2, 16'd1, 1, 1'b0);
        check("two_req_per_point", req_rises - r0, 4);
`else
        r0 = 0;
`endif

        // Abort while the third point (index 2) is requesting
        @(negedge clk);
        bus.cfg_f_start = 24'h001000;
        bus.cfg_f_step = 24'h000100;
        bus.cfg_npts = 8'd4;
        bus.cfg_settle = 16'd1;
        ack_delay = 3;
        cur_settle = 16'd1;
        fwq.push_back(24'h001000); fwq.push_back(24'h001100); fwq.push_back(24'h001200);
        push_mag(16'd10); push_mag(16'd20);
        base = fv_cnt;
        bus.start = 1'b1;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            @(posedge clk); n++; #1;
            bus.start = 1'b0;
            if (bus.meas_req && (fv_cnt - base == 3)) hit = 1'b1;
        end
        check("abort_point_reached", hit, 1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_req_low", bus.meas_req, 0);
        check("abort_busy_low", bus.busy, 0);
        check("abort_notch_idx", bus.notch_idx, last_res.idx);
        check("abort_notch_fw", bus.notch_fw, last_res.fw);
        check("abort_notch_mag", bus.notch_mag, last_res.mag);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_more_words", fwq.size(), 0);
        magq.delete();

        // Asynchronous reset in the middle of SETTLE
        @(negedge clk);
        bus.cfg_f_start = 24'h002000;
        bus.cfg_f_step = 24'h000001;
        bus.cfg_npts = 8'd2;
        bus.cfg_settle = 16'd10;
        ack_delay = 0;
        cur_settle = 16'd10;
        fwq.push_back(24'h002000);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("settle_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        check("reset_words_consumed", fwq.size(), 0);
        fwq.delete();
        magq.delete();
        doneq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
